// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder/subtractor controller.
// Accepts WIDTH-bit operands on a start/ready handshake, then runs one
// full-adder slice per clock, LSB first, with a registered carry.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   start, sub        request and operation select (0 = add, 1 = A - B)
//   a, b, carry_in    operands and add carry-in (ignored when subtracting)
//   ready, busy, done handshake/status (done is a one-cycle pulse)
//   sum, carry_out    result and MSB carry (subtract: 1 = no borrow)
//   ovf               signed overflow, held with sum until next completion
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             ovf
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PENULT_BIT = CNT_W'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry_reg;
    logic             msb_cin;
    logic [CNT_W-1:0] bit_cnt;

    logic slice_s;
    logic slice_c;
    logic accept;
    logic last_bit;
    logic ready_d;
    logic busy_d;
    logic done_d;

    // Start is only honoured once ready is actually visible to the requester.
    assign accept   = (state == IDLE) && ready && start;
    assign last_bit = (bit_cnt == LAST_BIT);

    // Single-bit full-adder slice shared across all bit positions.
    assign slice_s  = op_a[0] ^ op_b[0] ^ carry_reg;
    assign slice_c  = (op_a[0] & op_b[0]) | (op_a[0] & carry_reg) | (op_b[0] & carry_reg);
    assign res_next = {slice_s, res[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    next_state = FIN;
                end
            end
            FIN: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Status outputs are decoded from the upcoming state and then registered.
    always_comb begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (next_state)
            IDLE:    ready_d = 1'b1;
            RUN:     busy_d  = 1'b1;
            FIN:     done_d  = 1'b1;
            default: ready_d = 1'b0;
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            ready <= ready_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // Operand/result shift registers, carry, bit counter and held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            res       <= '0;
            carry_reg <= 1'b0;
            msb_cin   <= 1'b0;
            bit_cnt   <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Subtract is A + ~B + 1; carry_in is ignored then.
                        op_a      <= a;
                        op_b      <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : carry_in;
                        bit_cnt   <= '0;
                    end
                end
                RUN: begin
                    op_a      <= op_a >> 1;
                    op_b      <= op_b >> 1;
                    res       <= res_next;
                    carry_reg <= slice_c;
                    bit_cnt   <= bit_cnt + CNT_W'(1);
                    // Carry out of bit WIDTH-2 is the carry into the MSB.
                    if (bit_cnt == PENULT_BIT) begin
                        msb_cin <= slice_c;
                    end
                    // Publish on the FIN-entry edge so results coincide with done.
                    if (last_bit) begin
                        sum       <= res_next;
                        carry_out <= slice_c;
                        ovf       <= msb_cin ^ slice_c;
                    end
                end
                default: begin
                    bit_cnt <= bit_cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl (WIDTH=8): directed and random operations
// checked against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             carry_in = 1'b0;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             ovf;

    int unsigned total = 0;
    int unsigned passed = 0;
    logic [WIDTH-1:0] prev_sum = '0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .carry_in(carry_in), .ready(ready), .busy(busy), .done(done),
        .sum(sum), .carry_out(carry_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Reference: integer add of A, (B or ~B) and carry; overflow from signed range.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                               input logic msub, input logic mcin);
        logic [WIDTH-1:0] bb;
        int c0;
        int us;
        int ss;
        logic [31:0] uv;
        logic o;
        bb = msub ? ~mb : mb;
        c0 = msub ? 1 : int'(mcin);
        us = int'(ma) + int'(bb) + c0;
        ss = int'($signed(ma)) + int'($signed(bb)) + c0;
        uv = 32'(us);
        o  = (ss > 127) || (ss < -128);
        return {o, uv[WIDTH], uv[WIDTH-1:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 40 && !ready; i++) tick();
        check("ready_before_op", 32'(ready), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                         input logic osub, input logic ocin);
        logic [WIDTH+1:0] exp;
        exp = model(oa, ob, osub, ocin);
        wait_ready();
        a = oa; b = ob; sub = osub; carry_in = ocin; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            // Operands must not be resampled while running.
            a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'($urandom); start = 1'($urandom);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            check({tag, "_sum_hold"}, 32'(sum), 32'(prev_sum));
            tick();
        end
        start = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_fin"}, 32'(busy), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'(exp[WIDTH-1:0]));
        check({tag, "_cout"}, 32'(carry_out), 32'(exp[WIDTH]));
        check({tag, "_ovf"}, 32'(ovf), 32'(exp[WIDTH+1]));
        prev_sum = exp[WIDTH-1:0];
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_ready_after"}, 32'(ready), 32'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] av [0:30];
        logic [WIDTH-1:0] bv [0:30];
        int done_cnt;

        // Reset state.
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        #11 rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(ready), 32'd1);

        // Directed arithmetic from the plan, with literal expectations too.
        do_op("add1", 8'h5A, 8'h3C, 1'b0, 1'b0);
        check("add1_const", {22'd0, ovf, carry_out, sum}, {22'd0, 1'b1, 1'b0, 8'h96});
        // Result hold: 0+0 keeps 0x96 through RUN.
        do_op("zero", 8'h00, 8'h00, 1'b0, 1'b0);
        check("zero_const", 32'(sum), 32'h00);
        do_op("wrap0", 8'hFF, 8'h01, 1'b0, 1'b0);
        check("wrap0_const", {23'd0, carry_out, sum}, {23'd0, 1'b1, 8'h00});
        do_op("wrap1", 8'hFF, 8'h01, 1'b0, 1'b1);
        check("wrap1_const", {23'd0, carry_out, sum}, {23'd0, 1'b1, 8'h01});
        do_op("sub1", 8'h10, 8'h20, 1'b1, 1'b1);
        check("sub1_const", {22'd0, ovf, carry_out, sum}, {22'd0, 1'b0, 1'b0, 8'hF0});
        do_op("sub2", 8'h80, 8'h01, 1'b1, 1'b0);
        check("sub2_const", {22'd0, ovf, carry_out, sum}, {22'd0, 1'b1, 1'b1, 8'h7F});

        // Start held high with operands changing every cycle.
        wait_ready();
        sub = 1'b0; carry_in = 1'b0; start = 1'b1;
        av[0] = 8'h11; bv[0] = 8'h22; a = av[0]; b = bv[0];
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) done_cnt++;
            check("held_done", 32'(done), 32'((i == 8) || (i == 18) || (i == 28)));
            check("held_ready", 32'(ready), 32'((i == 9) || (i == 19) || (i == 29)));
            if (i == 8)  check("held_sum0", 32'(sum), 32'(WIDTH'(av[0] + bv[0])));
            if (i == 18) check("held_sum1", 32'(sum), 32'(WIDTH'(av[10] + bv[10])));
            if (i == 28) check("held_sum2", 32'(sum), 32'(WIDTH'(av[20] + bv[20])));
            av[i+1] = WIDTH'($urandom); bv[i+1] = WIDTH'($urandom);
            a = av[i+1]; b = bv[i+1];
        end
        start = 1'b0;
        check("held_done_count", 32'(done_cnt), 32'd3);
        prev_sum = WIDTH'(av[20] + bv[20]);

        // Asynchronous reset in the middle of an operation.
        wait_ready();
        a = 8'h40; b = 8'h05; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(carry_out), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        prev_sum = '0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        check("midrst_ready_after", 32'(ready), 32'd1);
        do_op("after_rst", 8'h01, 8'h02, 1'b0, 1'b0);
        check("after_rst_const", 32'(sum), 32'h03);

        // Random operations against the model.
        for (int n = 0; n < 24; n++) begin
            do_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder/subtractor controller.
- Accepts WIDTH-bit operands through a start/done handshake and sequences one internal single-bit full-adder slice over WIDTH clock cycles, LSB first, with a registered carry.
- Trades latency for area where a WIDTH-wide ripple chain of full adders is too large.
- Sits between a requesting unit (ALU sequencer, testbench) and the shared 1-bit adder datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when ready=1.
- sub  input  1  0 = add, 1 = subtract (A - B); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- carry_in  input  1  carry into bit 0 for add; ignored when sub=1.
- ready  output  1  high in IDLE; start accepted.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result outputs valid.
- sum  output  WIDTH  result, held until the next completion.
- carry_out  output  1  carry out of MSB (sub: 1 = no borrow).
- ovf  output  1  signed overflow = carry into MSB XOR carry_out.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous, any state, including mid-operation):
  - State goes to IDLE; all outputs, operand/result shift registers, carry register and bit counter clear to 0.
  - ready rises to 1 on the first clk edge after rst_n deasserts; it is 0 while rst_n=0.
  - Any operation in flight is discarded; no done pulse.
- States: IDLE, RUN, FIN.
- IDLE:
  - ready=1, busy=0, done=0.
  - On an edge with start=1: load opA<=a, opB<=(sub ? ~b : b), carry_reg<=(sub ? 1 : carry_in), bit_cnt<=0; go to RUN.
- RUN:
  - ready=0, busy=1.
  - Each edge: s=opA[0]^opB[0]^carry_reg and c=maj(opA[0],opB[0],carry_reg).
  - Shift opA/opB right by one; shift s into the result shift register at the MSB, right-shifting.
  - carry_reg<=c; bit_cnt<=bit_cnt+1.
  - On the edge with bit_cnt=WIDTH-2, also capture msb_cin<=c.
  - On the edge with bit_cnt=WIDTH-1: go to FIN.
- FIN (exactly one cycle):
  - busy=0, ready=0, done=1.
  - sum=result register, carry_out=carry_reg, ovf=msb_cin^carry_reg; these are registered and held after FIN until the next FIN or reset.
  - Next state is always IDLE.
- Latency: start sampled at edge k gives busy=1 after edges k..k+WIDTH-1, done=1 after edge k+WIDTH. Minimum issue interval is WIDTH+2 cycles.
- Handshake:
  - start while busy or in FIN is ignored; operands and sub are not re-sampled.
  - start held continuously is accepted again on the first IDLE edge.
- Arithmetic: modulo 2^WIDTH. Subtract uses two's complement (~b plus forced carry 1); carry_in is ignored.
- sum/carry_out/ovf do not change during RUN; they keep the previous result.

Test Plan (WIDTH=8):
1. Add: a=0x5A, b=0x3C, sub=0, carry_in=0 -> sum=0x96, carry_out=0, ovf=1. done exactly 8 edges after the start edge, busy high 8 cycles.
2. Add wrap: a=0xFF, b=0x01, carry_in=0 -> sum=0x00, carry_out=1, ovf=0. Repeat with carry_in=1 -> sum=0x01, carry_out=1.
3. Subtract:
   - a=0x10, b=0x20, sub=1, carry_in=1 (ignored) -> sum=0xF0, carry_out=0, ovf=0.
   - a=0x80, b=0x01, sub=1 -> sum=0x7F, carry_out=1, ovf=1.
4. Handshake: start held high for 30 cycles with a/b changed during RUN -> first result uses the values sampled at the accepted edge. Second op accepted on the IDLE edge after done, with a one-cycle ready=1 gap. No done pulses other than one per op.
5. Mid-operation reset: pull rst_n low after 3 RUN edges -> ready/busy/done/sum/carry_out/ovf all 0 immediately (asynchronous). No done pulse. After release, ready=1; the op 0x01+0x02 gives sum=0x03.
6. Result hold: after op 1 completes, issue 0x00+0x00 -> sum stays 0x96 throughout RUN, then becomes 0x00 at done.
